// File: rtl/bcd_tick_counter.sv
// Multi-digit up/down radix counter with a built-in prescaler and active-low 7-segment outputs.
// Optional leading-zero blanking is enabled by defining BCD_TICK_COUNTER_BLANK_EN.
module bcd_tick_counter #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1,
  parameter int DIGITS  = 2,
  parameter int RADIX   = 10
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  wrap,
  output logic [7*DIGITS-1:0]   HEX
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [3:0] DIG_MAX = 4'(RADIX - 1);

  logic [PW-1:0]       prescaler;
  logic [4*DIGITS-1:0] count_next;
  logic [4*DIGITS-1:0] load_clean;
  logic                carry;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0011000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign tick = enable && (prescaler == PRE_LAST);

  // Ripple carry/borrow through the digits; a surviving carry means full roll-over.
  always_comb begin
    count_next = count;
    load_clean = load_value;
    carry      = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_value[4*i +: 4] > DIG_MAX) begin
        load_clean[4*i +: 4] = 4'd0;
      end else begin
        load_clean[4*i +: 4] = load_value[4*i +: 4];
      end
      if (!carry) begin
        count_next[4*i +: 4] = count[4*i +: 4];
      end else if (up) begin
        if (count[4*i +: 4] == DIG_MAX) begin
          count_next[4*i +: 4] = 4'd0;
        end else begin
          count_next[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end else begin
        if (count[4*i +: 4] == 4'd0) begin
          count_next[4*i +: 4] = DIG_MAX;
        end else begin
          count_next[4*i +: 4] = count[4*i +: 4] - 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Load wins over a coincident tick; a held counter never raises wrap.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      prescaler <= '0;
      count     <= '0;
      wrap      <= 1'b0;
    end else if (load) begin
      prescaler <= '0;
      count     <= load_clean;
      wrap      <= 1'b0;
    end else if (enable) begin
      if (tick) begin
        prescaler <= '0;
        count     <= count_next;
        wrap      <= carry;
      end else begin
        prescaler <= prescaler + PW'(1);
        wrap      <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

`ifdef BCD_TICK_COUNTER_BLANK_EN
  logic lead_zero;
`endif

  // Segment decode, scanning from the most significant digit for blanking.
  always_comb begin
    HEX = '1;
`ifdef BCD_TICK_COUNTER_BLANK_EN
    lead_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead_zero = lead_zero && (count[4*i +: 4] == 4'd0);
      if (lead_zero && (i != 0)) begin
        HEX[7*i +: 7] = 7'b1111111;
      end else begin
        HEX[7*i +: 7] = seg7(count[4*i +: 4]);
      end
    end
`else
    for (int i = 0; i < DIGITS; i++) begin
      HEX[7*i +: 7] = seg7(count[4*i +: 4]);
    end
`endif
  end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed-vector bench for bcd_tick_counter at PRESCALE=10, two decimal digits.
module tb_bcd_tick_counter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        up;
  logic        load;
  logic [7:0]  load_value;
  logic [7:0]  count;
  logic        tick;
  logic        wrap;
  logic [13:0] hex;

  int vectors = 0;
  int miscompares = 0;

  bcd_tick_counter #(.CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .RADIX(10)) dut (
    .CLOCK_50(clk), .resetn(resetn), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .count(count), .tick(tick), .wrap(wrap), .HEX(hex)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    load_value = v;
    step(1);
    load = 1'b0;
  endtask

  logic [6:0] hi_zero_exp;

  initial begin
`ifdef BCD_TICK_COUNTER_BLANK_EN
    hi_zero_exp = 7'b1111111;
`else
    hi_zero_exp = 7'b1000000;
`endif
    resetn = 1'b0; enable = 1'b0; up = 1'b1; load = 1'b0; load_value = 8'h00;
    #12;
    check_vec("rst_count", 32'(count), 32'h00);
    check_vec("rst_tick", 32'(tick), 32'h0);
    check_vec("rst_wrap", 32'(wrap), 32'h0);
    check_vec("rst_hex_lo", 32'(hex[6:0]), 32'(7'b1000000));
    check_vec("rst_hex_hi", 32'(hex[13:7]), 32'(hi_zero_exp));

    // Cycle 0 begins at release; ticks expected in cycles 9 and 19.
    enable = 1'b1;
    #2 resetn = 1'b1;
    for (int c = 0; c < 25; c++) begin
      check_vec("run_tick", 32'(tick), 32'((c == 9) || (c == 19)));
      if (c == 10) check_vec("run_cnt1", 32'(count), 32'h01);
      if (c == 20) begin
        check_vec("run_cnt2", 32'(count), 32'h02);
        check_vec("run_hex2", 32'(hex[6:0]), 32'(7'b0100100));
      end
      step(1);
    end

    // Up roll-over 99 -> 00
    do_load(8'h99);
    check_vec("ld99", 32'(count), 32'h99);
    step(9);
    check_vec("up_wrap_tick", 32'(tick), 32'h1);
    step(1);
    check_vec("up_wrap_cnt", 32'(count), 32'h00);
    check_vec("up_wrap", 32'(wrap), 32'h1);
    step(1);
    check_vec("up_wrap_clr", 32'(wrap), 32'h0);

    // Down roll-over 00 -> 99 -> 98
    up = 1'b0;
    do_load(8'h00);
    step(10);
    check_vec("dn_wrap_cnt", 32'(count), 32'h99);
    check_vec("dn_wrap", 32'(wrap), 32'h1);
    step(10);
    check_vec("dn_cnt98", 32'(count), 32'h98);
    check_vec("dn_nowrap", 32'(wrap), 32'h0);

    // Borrow across digits without roll-over
    do_load(8'h10);
    step(10);
    check_vec("dn_borrow", 32'(count), 32'h09);
    check_vec("dn_borrow_wrap", 32'(wrap), 32'h0);

    // Load coincident with a tick
    up = 1'b1;
    step(9);
    check_vec("ld_tick_pre", 32'(tick), 32'h1);
    do_load(8'h37);
    check_vec("ld_tick_cnt", 32'(count), 32'h37);
    check_vec("ld_tick_wrap", 32'(wrap), 32'h0);
    step(10);
    check_vec("ld_tick_next", 32'(count), 32'h38);

    // Hold at prescaler=4 for 7 cycles, then resume
    step(4);
    enable = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check_vec("hold_tick", 32'(tick), 32'h0);
      check_vec("hold_cnt", 32'(count), 32'h38);
      step(1);
    end
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_vec("resume_wait", 32'(tick), 32'h0);
      step(1);
    end
    check_vec("resume_tick", 32'(tick), 32'h1);
    step(1);
    check_vec("resume_cnt", 32'(count), 32'h39);

    // Out-of-range digit stored as zero; leading-digit display
    do_load(8'hA5);
    check_vec("ld_clean", 32'(count), 32'h05);
    check_vec("hex_lo5", 32'(hex[6:0]), 32'(7'b0010010));
    check_vec("hex_hi0", 32'(hex[13:7]), 32'(hi_zero_exp));

    // Asynchronous reset mid-period
    step(3);
    #2 resetn = 1'b0;
    #1;
    check_vec("async_cnt", 32'(count), 32'h00);
    check_vec("async_hex", 32'(hex[6:0]), 32'(7'b1000000));
    check_vec("async_tick", 32'(tick), 32'h0);
    step(2);
    check_vec("async_hold", 32'(count), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
